// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register with flush, independent sideband
// register and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int KEEP_W     = 66,
  parameter int KEEP_FLUSH = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              keep_en,
  input  logic [KEEP_W-1:0] in_keep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic              push, pop;

  assign in_ready   = ~skid_v_q;
  assign out_valid  = main_v_q;
  assign out_data   = main_d_q;
  assign out_keep   = keep_q;
  assign occ        = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign bubble_cnt = bcnt_q;

  assign push = in_valid & ~skid_v_q;
  assign pop  = main_v_q & out_ready;

  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (flush) begin
      main_v_d = 1'b0;
      main_d_d = '0;
      skid_v_d = 1'b0;
      skid_d_d = '0;
    end else begin
      unique case (1'b1)
        !main_v_q: begin
          if (push) begin
            main_v_d = 1'b1;
            main_d_d = in_data;
          end
        end
        main_v_q && !skid_v_q: begin
          if (push && pop) begin
            main_d_d = in_data;
          end else if (push) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data;
          end else if (pop) begin
            main_v_d = 1'b0;
            main_d_d = '0;
          end
        end
        skid_v_q: begin
          // full: in_ready is low, so only a pop can move data
          if (pop) begin
            main_d_d = skid_d_q;
            skid_v_d = 1'b0;
            skid_d_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    keep_d = keep_q;
    if (flush && (KEEP_FLUSH != 0)) begin
      keep_d = '0;
    end else if (keep_en) begin
      keep_d = in_keep;
    end
  end

  always_comb begin
    bcnt_d = bcnt_q;
    if (out_ready && !main_v_q && (bcnt_q != CNT_MAX)) begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      main_d_q <= '0;
      skid_v_q <= 1'b0;
      skid_d_q <= '0;
      keep_q   <= '0;
      bcnt_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      main_d_q <= main_d_d;
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
      keep_q   <= keep_d;
      bcnt_q   <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: vector table for the handshake path, hand sequences
// for the sideband register and the bubble counter.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, keep_en;
  logic [31:0] in_data;
  logic [65:0] in_keep;

  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [65:0] out_keep0;
  logic [1:0]  occ0;
  logic [15:0] bcnt0;

  logic        in_ready1, out_valid1;
  logic [31:0] out_data1;
  logic [65:0] out_keep1;
  logic [1:0]  occ1;
  logic [3:0]  bcnt1;

  always #5 clk = ~clk;

  pipe_stage_reg u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .keep_en(keep_en), .in_keep(in_keep),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_keep(out_keep0),
    .occ(occ0), .bubble_cnt(bcnt0)
  );

  pipe_stage_reg #(.CNT_W(4), .KEEP_FLUSH(0)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .keep_en(keep_en), .in_keep(in_keep),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_keep(out_keep1),
    .occ(occ1), .bubble_cnt(bcnt1)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eocc;
    logic        eir;
  } vec_t;

  vec_t tv[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [65:0] K1 = 66'h2_DEAD_BEEF_0000_0001;
  localparam logic [65:0] K2 = 66'h1_0123_4567_89AB_CDEF;
  localparam logic [65:0] K3 = 66'h0_0000_0000_0000_0055;

  task automatic add(input logic r, input logic f, input logic iv,
                     input logic [31:0] id, input logic o,
                     input logic ev, input logic [31:0] ed,
                     input logic [1:0] eo, input logic ei);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = o;
    v.ev = ev; v.ed = ed; v.eocc = eo; v.eir = ei;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [65:0] act,
                     input logic [65:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [31:0] id, input logic o,
                       input logic ke, input logic [65:0] k);
    rst = r; flush = f; in_valid = iv; in_data = id;
    out_ready = o; keep_en = ke; in_keep = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; keep_en = 1'b0; in_keep = '0;

    //  rst f iv data     ordy ev data     occ ir
    add(1, 0, 0, 32'h00, 0,   0, 32'h00, 0, 1);
    add(0, 0, 1, 32'h11, 1,   1, 32'h11, 1, 1);
    add(0, 0, 1, 32'h22, 1,   1, 32'h22, 1, 1);
    add(0, 0, 1, 32'h33, 1,   1, 32'h33, 1, 1);
    add(0, 0, 0, 32'h00, 1,   0, 32'h00, 0, 1);
    add(0, 0, 1, 32'hA1, 0,   1, 32'hA1, 1, 1);
    add(0, 0, 1, 32'hA2, 0,   1, 32'hA1, 2, 0);
    add(0, 0, 1, 32'hEE, 0,   1, 32'hA1, 2, 0);
    add(0, 0, 0, 32'h00, 1,   1, 32'hA2, 1, 1);
    add(0, 0, 0, 32'h00, 1,   0, 32'h00, 0, 1);
    add(0, 0, 1, 32'hB1, 0,   1, 32'hB1, 1, 1);
    add(0, 0, 1, 32'hB2, 0,   1, 32'hB1, 2, 0);
    add(0, 1, 1, 32'hFF, 1,   0, 32'h00, 0, 1);
    add(0, 0, 0, 32'h00, 1,   0, 32'h00, 0, 1);
    add(0, 0, 1, 32'hC1, 0,   1, 32'hC1, 1, 1);
    add(0, 1, 1, 32'hC2, 1,   0, 32'h00, 0, 1);
    add(0, 0, 0, 32'h00, 1,   0, 32'h00, 0, 1);
    add(0, 0, 1, 32'hD1, 0,   1, 32'hD1, 1, 1);
    add(0, 0, 1, 32'hD2, 0,   1, 32'hD1, 2, 0);
    add(1, 0, 1, 32'hD3, 1,   0, 32'h00, 0, 1);
    add(0, 0, 0, 32'h00, 1,   0, 32'h00, 0, 1);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].flush, tv[i].iv, tv[i].id, tv[i].ordy,
            1'b0, '0);
      chk($sformatf("vec%0d", i),
          {30'd0, out_valid0, out_data0, occ0, in_ready0},
          {30'd0, tv[i].ev, tv[i].ed, tv[i].eocc, tv[i].eir});
    end

    // sideband register
    drive(1, 0, 0, 0, 0, 0, '0);
    chk("rst_keep", out_keep0, '0);
    chk("rst_bcnt", {50'd0, bcnt0}, '0);
    drive(0, 0, 1, 32'hE1, 0, 0, '0);
    drive(0, 0, 1, 32'hE2, 0, 0, '0);
    drive(0, 0, 0, 0, 0, 1, K1);
    chk("keep_full_occ", {64'd0, occ0}, 66'd2);
    chk("keep_full_u0", out_keep0, K1);
    chk("keep_full_u1", out_keep1, K1);
    drive(0, 1, 0, 0, 0, 0, '0);
    chk("keep_flush_u0", out_keep0, '0);
    chk("keep_noflush_u1", out_keep1, K1);
    drive(0, 0, 0, 0, 0, 1, K2);
    chk("keep_empty_u0", out_keep0, K2);
    drive(0, 1, 0, 0, 0, 1, K3);
    chk("keep_flush_ovr_u0", out_keep0, '0);
    chk("keep_flush_ld_u1", out_keep1, K3);

    // reset while full
    drive(0, 0, 1, 32'hF1, 0, 1, K1);
    drive(0, 0, 1, 32'hF2, 0, 0, '0);
    chk("pre_rst_occ", {64'd0, occ0}, 66'd2);
    drive(1, 0, 0, 0, 1, 1, K2);
    chk("rst_mid", {30'd0, out_valid0, out_data0, occ0, in_ready0},
        {30'd0, 1'b0, 32'd0, 2'd0, 1'b1});
    chk("rst_mid_keep", out_keep0, '0);
    drive(0, 0, 0, 0, 1, 0, '0);
    chk("post_rst_ov", {65'd0, out_valid0}, '0);

    // bubble counter
    drive(1, 0, 0, 0, 0, 0, '0);
    chk("cnt_rst", {62'd0, bcnt1}, '0);
    for (int c = 0; c < 20; c++) drive(0, 0, 0, 0, 1, 0, '0);
    chk("cnt_sat_u1", {62'd0, bcnt1}, 66'd15);
    chk("cnt_u0", {50'd0, bcnt0}, 66'd20);
    drive(0, 1, 0, 0, 1, 0, '0);
    chk("cnt_flush_u1", {62'd0, bcnt1}, 66'd15);
    chk("cnt_flush_u0", {50'd0, bcnt0}, 66'd21);
    drive(0, 0, 1, 32'h77, 0, 0, '0);
    drive(0, 0, 0, 0, 1, 0, '0);
    chk("cnt_busy_u0", {50'd0, bcnt0}, 66'd21);
    drive(1, 0, 0, 0, 1, 0, '0);
    chk("cnt_rst2_u1", {62'd0, bcnt1}, '0);
    chk("cnt_rst2_u0", {50'd0, bcnt0}, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, which sets the width of the payload field carried with the handshake.
REQ-002 SHALL have parameter KEEP_W, default 66, which sets the width of the sideband "keep" field that updates independently of the handshake (multiply/divide state).
REQ-003 SHALL have parameter KEEP_FLUSH, default 1, where 1 means flush clears the keep field and 0 means flush leaves it untouched.
REQ-004 SHALL have parameter CNT_W, default 16, which sets the width of the bubble performance counter.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 flush  input  1  exception/branch flush; kills every held entry.
REQ-009 in_valid  input  1  upstream stage presents an entry.
REQ-010 in_ready  output  1  stage can accept an entry this cycle.
REQ-011 in_data  input  DATA_W  upstream payload.
REQ-012 keep_en  input  1  load in_keep this cycle.
REQ-013 in_keep  input  KEEP_W  sideband value.
REQ-014 out_valid  output  1  downstream entry valid.
REQ-015 out_ready  input  1  downstream accepts the entry.
REQ-016 out_data  output  DATA_W  downstream payload.
REQ-017 out_keep  output  KEEP_W  registered sideband value.
REQ-018 occ  output  2  number of entries held (0, 1 or 2).
REQ-019 bubble_cnt  output  CNT_W  count of cycles in which downstream was ready but no entry was valid.

Function
REQ-020 SHALL hold two entries, main and skid, each a valid bit plus DATA_W bits of data; out_valid/out_data SHALL come from main.
REQ-021 in_ready SHALL equal NOT skid_valid, driven directly from a register with no combinational path from out_ready.
REQ-022 A push SHALL occur when in_valid and in_ready are both high; a pop SHALL occur when out_valid and out_ready are both high.
REQ-023 Transitions for the empty, one-entry and full states:
- Empty + push -> main loads the entry (one-cycle latency from in_valid to out_valid).
- Main only + push + pop -> main loads the new entry.
- Main only + push, no pop -> skid loads the entry.
- Main only + pop, no push -> empty.
- Full + pop -> main takes skid and skid empties; no push is possible.
REQ-024 Entry order SHALL be strictly FIFO; an entry SHALL never be dropped or duplicated.
REQ-025 out_data SHALL be all-zero whenever out_valid=0 (NOP encoding); an invalidated entry's data register SHALL be cleared to 0.
REQ-026 occ SHALL equal main_valid + skid_valid.
REQ-027 flush=1 SHALL invalidate and zero both entries at the next edge.
REQ-028 flush SHALL take priority over a simultaneous push and pop; the pushed entry SHALL be discarded.
REQ-029 in_ready SHALL be 1 in the cycle after a flush.
REQ-030 out_keep SHALL load in_keep on each edge where keep_en=1, regardless of handshake state, including when the stage is full or empty.
REQ-031 With KEEP_FLUSH=1, flush SHALL zero out_keep, overriding keep_en; with KEEP_FLUSH=0, flush SHALL not affect out_keep.
REQ-032 bubble_cnt SHALL increment on each edge where out_ready=1 and out_valid=0, SHALL saturate at 2^CNT_W-1, and SHALL be unaffected by flush.
REQ-033 in_valid SHALL be ignored while in_ready=0, and in_data SHALL not be sampled in that cycle.

Reset
REQ-034 rst=1 SHALL drive the following at the next edge: main and skid invalid, out_data=0, out_keep=0, occ=0, bubble_cnt=0, in_ready=1.
REQ-035 rst SHALL take priority over flush, push, pop and keep_en.
REQ-036 rst asserted mid-transfer SHALL discard held entries, with no output activity in the cycle after reset releases.

Verification
REQ-037 Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> same values appear one cycle later, back-to-back, occ=1 throughout.
REQ-038 Backpressure: out_ready=0, push 0xA1,0xA2 -> occ=2, in_ready=0; raise out_ready -> 0xA1 then 0xA2, in_ready=1 after the first pop.
REQ-039 Flush collision: full stage, flush=1 together with in_valid=1 (0xFF) -> next cycle out_valid=0, out_data=0, occ=0, 0xFF never appears.
REQ-040 Keep path: occ=2, out_ready=0, keep_en=1, in_keep=0x2_DEAD_BEEF_0000_0001 -> out_keep takes the value next cycle; flush with KEEP_FLUSH=1 -> 0; with KEEP_FLUSH=0 -> unchanged.
REQ-041 Counter: CNT_W=4, out_ready=1, no input for 20 cycles -> bubble_cnt reaches 15 and holds; flush leaves it at 15; rst -> 0.
REQ-042 Reset mid-operation: occ=2, rst=1 for one cycle -> occ=0, out_keep=0, in_ready=1, no stale entry afterwards.
